usb_fs_line_tx: RTL and testbench
=================================

USB_FS_LINE_TX -- requirements
Module: usb_fs_line_tx

Interface
REQ-001 The module SHALL have these ports:
- clk_48mhz  input  1  sole clock, 48 MHz; one USB full-speed bit period is 4 clocks.
- reset_n  input  1  synchronous, active-low reset.
- tx_pkt_start  input  1  one-cycle request to start a packet.
- tx_data_valid  input  1  tx_data holds the next packet byte.
- tx_data  input  8  packet byte, sent LSB first.
- tx_data_get  output  1  one-cycle strobe; tx_data was loaded this cycle.
- tx_busy  output  1  a packet is in progress (SYNC through EOP).
- usb_p_tx  output  1  D+ drive value to the PHY.
- usb_n_tx  output  1  D- drive value to the PHY.
- usb_tx_en  output  1  PHY output enable.

REQ-002 All outputs SHALL be registered.

Function
REQ-003 Bit timing: a free-running 2-bit phase counter SHALL restart at 0 when a packet is accepted. Line outputs SHALL change only on phase 0, so each line state is held exactly 4 clocks.

REQ-004 States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.

REQ-005 IDLE, accept: tx_pkt_start=1 in IDLE SHALL cause the following on the next cycle:
- state goes to SYNC;
- tx_busy=1 and usb_tx_en=1;
- the first SYNC bit is driven.

REQ-006 IDLE, ignore: tx_pkt_start in any other state SHALL be ignored.

REQ-007 SYNC: SYNC SHALL be byte 0x80 sent LSB first, giving line states K J K J K J K K.

REQ-008 Line coding: J = (p=1, n=0), K = (p=0, n=1), SE0 = (p=0, n=0).

REQ-009 NRZI: a 0 bit SHALL toggle J/K; a 1 bit SHALL hold the current state. NRZI state SHALL be J at packet start.

REQ-010 Bit stuffing: after six consecutive 1 bits, one extra 0 bit SHALL be inserted.
- The run counter SHALL include the final SYNC bit and SHALL span byte boundaries.
- The counter SHALL clear on any 0 bit, including the stuffed bit.
- A stuff bit that falls due after the last data bit SHALL be sent before EOP.

REQ-011 Byte fetch: on the phase-0 cycle where a new byte is needed (after the last SYNC bit, or after bit 7 plus any pending stuff bit), the module SHALL sample tx_data_valid.
- If 1: load tx_data, pulse tx_data_get for exactly that cycle, and send bit 0 in that bit period.
- If 0: go to EOP_SE0.
- A packet with zero data bytes is legal (SYNC then EOP).

REQ-012 EOP sequence: EOP_SE0 SHALL drive SE0 for 2 bit periods (8 clocks), then EOP_J SHALL drive J for 1 bit period.

REQ-013 Return to IDLE: after EOP_J the module SHALL return to IDLE with usb_tx_en=0 and tx_busy=0 on the same cycle. The earliest new accept SHALL be that same IDLE cycle.

REQ-014 Idle outputs: in IDLE, usb_p_tx=1, usb_n_tx=0, tx_data_get=0.

Reset
REQ-015 While reset_n=0 at a clock edge, on the next cycle:
- state=IDLE, tx_busy=0, usb_tx_en=0, usb_p_tx=1, usb_n_tx=0, tx_data_get=0;
- phase, stuff counter and shift register cleared.

REQ-016 Reset mid-packet SHALL abandon the packet immediately with no EOP. tx_pkt_start during reset SHALL be ignored.

Configuration
REQ-017 Macro USB_TX_PKT_ABORT_EN SHALL control the abort feature.

REQ-018 With USB_TX_PKT_ABORT_EN defined, input tx_abort (1 bit) SHALL exist.
- tx_abort=1 in SYNC or DATA SHALL, from the next bit boundary, send 8 consecutive 1 bits with stuffing suppressed (a deliberate stuff error), then the normal EOP.
- No further tx_data_get SHALL occur after the abort.
- tx_abort SHALL be ignored in IDLE, EOP_SE0 and EOP_J.

REQ-019 Without USB_TX_PKT_ABORT_EN, the tx_abort port and its logic SHALL be absent. Behaviour SHALL otherwise be identical.

Verification
REQ-020 Reset/idle: hold reset_n=0 for 3 clocks, then release. Required: usb_tx_en=0, p=1, n=0, tx_busy=0, tx_data_get=0 throughout 20 idle clocks.

REQ-021 Single byte: pulse tx_pkt_start with tx_data=0xA5 valid. Required:
- line sequence K J K J K J K K | K J J K J J K K | SE0 SE0 J, each held 4 clocks;
- 76 clocks total;
- one tx_data_get, aligned with the first 0xA5 bit.

REQ-022 Stuffing: send bytes 0xFF, 0xFF, then valid=0. Required:
- stuff (toggle) after byte0 bit 4 and after byte1 bit 2;
- 29 bit periods (116 clocks) from first SYNC bit to usb_tx_en=0;
- exactly 2 tx_data_get pulses.

REQ-023 Zero-length packet and busy start:
- tx_pkt_start with tx_data_valid=0 gives SYNC, SE0 SE0 J (44 clocks).
- A second tx_pkt_start pulse at clock 10 SHALL be ignored: no second SYNC.

REQ-024 Reset mid-packet: assert reset_n=0 during byte 0 bit 3. Required: next cycle usb_tx_en=0, p=1, n=0; no EOP is emitted.

REQ-025 Abort (USB_TX_PKT_ABORT_EN): assert tx_abort during byte 0 bit 2 of a 3-byte packet. Required:
- 8 unchanging line states, then SE0 SE0 J;
- only 1 tx_data_get in total.

Source files
------------

// File: rtl/usb_fs_line_tx.sv
// USB full-speed line transmitter: SYNC, NRZI coding, bit stuffing, EOP; 4 clocks per bit at 48 MHz.
// Optional abort (deliberate stuff error) enabled by defining USB_TX_PKT_ABORT_EN.
module usb_fs_line_tx (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       tx_pkt_start,
   input  logic       tx_data_valid,
   input  logic [7:0] tx_data,
`ifdef USB_TX_PKT_ABORT_EN
   input  logic       tx_abort,
`endif
   output logic       tx_data_get,
   output logic       tx_busy,
   output logic       usb_p_tx,
   output logic       usb_n_tx,
   output logic       usb_tx_en
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_EOP_SE0,
      S_EOP_J
   } state_t;

   state_t      r_state;
   logic [1:0]  r_phase;
   logic [6:0]  r_shift;
   logic [2:0]  r_bit_cnt;
   logic [2:0]  r_ones;
   logic        r_nrzi;
   logic        r_eop_cnt;
   logic        r_get;
   logic        r_busy;
   logic        r_p;
   logic        r_n;
   logic        r_en;

   logic        w_boundary;
   logic        w_abort_act;
   logic        w_abort_done;
   logic        w_drive;
   logic        w_bit;
   logic        w_shift;
   logic        w_fetch;
   logic        w_to_eop;
   logic        w_nrzi_nx;

   assign w_boundary = (r_phase == 2'd3);

`ifdef USB_TX_PKT_ABORT_EN
   logic       r_abort;
   logic [3:0] r_abort_cnt;

   assign w_abort_act  = r_abort | tx_abort;
   assign w_abort_done = (r_abort_cnt == 4'd8);

   // Abort latch and count of unstuffed 1 bits already sent
   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         r_abort     <= 1'b0;
         r_abort_cnt <= 4'd0;
      end else if (r_state == S_SYNC || r_state == S_DATA) begin
         if (tx_abort)
            r_abort <= 1'b1;
         if (w_boundary && w_abort_act && !w_abort_done)
            r_abort_cnt <= r_abort_cnt + 4'd1;
      end else begin
         r_abort     <= 1'b0;
         r_abort_cnt <= 4'd0;
      end
   end
`else
   assign w_abort_act  = 1'b0;
   assign w_abort_done = 1'b0;
`endif

   // Choose what the next bit period carries; stuffing outranks the byte sequence
   always_comb begin
      w_drive  = 1'b0;
      w_bit    = 1'b1;
      w_shift  = 1'b0;
      w_fetch  = 1'b0;
      w_to_eop = 1'b0;
      if (r_state == S_SYNC || r_state == S_DATA) begin
         if (w_abort_act) begin
            if (w_abort_done)
               w_to_eop = 1'b1;
            else
               w_drive = 1'b1;
         end else if (r_ones == 3'd6) begin
            w_drive = 1'b1;
            w_bit   = 1'b0;
         end else if (r_bit_cnt != 3'd7) begin
            w_drive = 1'b1;
            w_bit   = r_shift[0];
            w_shift = 1'b1;
         end else if (tx_data_valid) begin
            w_drive = 1'b1;
            w_bit   = tx_data[0];
            w_fetch = 1'b1;
         end else begin
            w_to_eop = 1'b1;
         end
      end
   end

   assign w_nrzi_nx = w_bit ? r_nrzi : ~r_nrzi;

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_phase   <= 2'd0;
         r_shift   <= 7'd0;
         r_bit_cnt <= 3'd0;
         r_ones    <= 3'd0;
         r_nrzi    <= 1'b1;
         r_eop_cnt <= 1'b0;
         r_get     <= 1'b0;
         r_busy    <= 1'b0;
         r_p       <= 1'b1;
         r_n       <= 1'b0;
         r_en      <= 1'b0;
      end else begin
         r_phase <= r_phase + 2'd1;
         r_get   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_pkt_start) begin
                  // SYNC is 0x80 LSB first; its first 0 bit moves the line from J to K
                  r_state   <= S_SYNC;
                  r_phase   <= 2'd0;
                  r_shift   <= 7'h40;
                  r_bit_cnt <= 3'd0;
                  r_ones    <= 3'd0;
                  r_nrzi    <= 1'b0;
                  r_p       <= 1'b0;
                  r_n       <= 1'b1;
                  r_busy    <= 1'b1;
                  r_en      <= 1'b1;
               end
            end
            S_SYNC, S_DATA: begin
               if (w_boundary) begin
                  if (w_drive) begin
                     r_nrzi <= w_nrzi_nx;
                     r_p    <= w_nrzi_nx;
                     r_n    <= ~w_nrzi_nx;
                     r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
                  end
                  if (w_shift) begin
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
                  if (w_fetch) begin
                     r_shift   <= tx_data[7:1];
                     r_bit_cnt <= 3'd0;
                     r_get     <= 1'b1;
                     r_state   <= S_DATA;
                  end
                  if (w_to_eop) begin
                     r_state   <= S_EOP_SE0;
                     r_eop_cnt <= 1'b0;
                     r_p       <= 1'b0;
                     r_n       <= 1'b0;
                  end
               end
            end
            S_EOP_SE0: begin
               if (w_boundary) begin
                  if (!r_eop_cnt) begin
                     r_eop_cnt <= 1'b1;
                  end else begin
                     r_state <= S_EOP_J;
                     r_nrzi  <= 1'b1;
                     r_p     <= 1'b1;
                     r_n     <= 1'b0;
                  end
               end
            end
            S_EOP_J: begin
               if (w_boundary) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_en    <= 1'b0;
                  r_p     <= 1'b1;
                  r_n     <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_data_get = r_get;
   assign tx_busy     = r_busy;
   assign usb_p_tx    = r_p;
   assign usb_n_tx    = r_n;
   assign usb_tx_en   = r_en;

endmodule

// File: tb/tb_usb_fs_line_tx.sv
// Directed bench for usb_fs_line_tx; abort scenario included when USB_TX_PKT_ABORT_EN is defined.
module tb_usb_fs_line_tx;

   localparam logic [1:0] LJ = 2'b01;
   localparam logic [1:0] LK = 2'b10;
   localparam logic [1:0] LS = 2'b00;

   logic       clk_48mhz = 1'b0;
   logic       reset_n;
   logic       tx_pkt_start;
   logic       tx_data_valid;
   logic [7:0] tx_data;
`ifdef USB_TX_PKT_ABORT_EN
   logic       tx_abort;
`endif
   logic       tx_data_get;
   logic       tx_busy;
   logic       usb_p_tx;
   logic       usb_n_tx;
   logic       usb_tx_en;

   int checks = 0;
   int errors = 0;

   logic [7:0] tb_bytes [0:3];
   int         tb_nbytes;

   usb_fs_line_tx dut (
      .clk_48mhz     (clk_48mhz),
      .reset_n       (reset_n),
      .tx_pkt_start  (tx_pkt_start),
      .tx_data_valid (tx_data_valid),
      .tx_data       (tx_data),
`ifdef USB_TX_PKT_ABORT_EN
      .tx_abort      (tx_abort),
`endif
      .tx_data_get   (tx_data_get),
      .tx_busy       (tx_busy),
      .usb_p_tx      (usb_p_tx),
      .usb_n_tx      (usb_n_tx),
      .usb_tx_en     (usb_tx_en)
   );

   always #10 clk_48mhz = ~clk_48mhz;

   logic [1:0] w_code;
   assign w_code = {usb_n_tx, usb_p_tx};

   // Packet recorder: one line state per 4-clock bit period, plus timing of tx_data_get
   logic       prev_en = 1'b0;
   logic [1:0] mon_ph = 2'd0;
   logic [1:0] mon_line [0:63];
   int         mon_n = 0;
   int         mon_en_clks = 0;
   int         mon_gets = 0;
   int         mon_glitch = 0;
   int         mon_busy_err = 0;
   int         mon_get_pos [0:3];

   always @(negedge clk_48mhz) begin
      prev_en <= usb_tx_en;
      if (usb_tx_en === 1'b1 && prev_en !== 1'b1) begin
         mon_n        <= 1;
         mon_line[0]  <= w_code;
         mon_ph       <= 2'd1;
         mon_en_clks  <= 1;
         mon_gets     <= 0;
         mon_glitch   <= 0;
         mon_busy_err <= (tx_busy !== 1'b1) ? 1 : 0;
      end else if (usb_tx_en === 1'b1) begin
         mon_en_clks <= mon_en_clks + 1;
         mon_ph      <= mon_ph + 2'd1;
         if (mon_ph == 2'd0) begin
            if (mon_n < 64) mon_line[mon_n] <= w_code;
            mon_n <= mon_n + 1;
         end else if (mon_n > 0 && mon_n <= 64 && w_code !== mon_line[mon_n-1]) begin
            mon_glitch <= mon_glitch + 1;
         end
         if (tx_data_get === 1'b1) begin
            if (mon_gets < 4) mon_get_pos[mon_gets] <= mon_en_clks;
            mon_gets <= mon_gets + 1;
         end
         if (tx_busy !== 1'b1) mon_busy_err <= mon_busy_err + 1;
      end
   end

   // Start a packet from tb_bytes, feed bytes on each tx_data_get, optionally pulse start/abort at clock k
   task automatic send_packet(input int start_at, input int abort_at, output int timed_out);
      int idx;
      int k;
      idx = 0;
      tx_data = tb_bytes[0];
      tx_data_valid = (tb_nbytes > 0);
      @(negedge clk_48mhz);
      tx_pkt_start = 1'b1;
      @(negedge clk_48mhz);
      tx_pkt_start = 1'b0;
      k = 0;
      while (usb_tx_en === 1'b1 && k < 400) begin
         if (tx_data_get === 1'b1) begin
            idx = idx + 1;
            tx_data = (idx < tb_nbytes) ? tb_bytes[idx] : 8'h00;
            tx_data_valid = (idx < tb_nbytes);
         end
         tx_pkt_start = (k == start_at);
`ifdef USB_TX_PKT_ABORT_EN
         tx_abort = (k == abort_at);
`else
         if (abort_at >= 0 && k == abort_at) tx_pkt_start = 1'b0;
`endif
         @(negedge clk_48mhz);
         k = k + 1;
      end
      tx_pkt_start = 1'b0;
      tx_data_valid = 1'b0;
`ifdef USB_TX_PKT_ABORT_EN
      tx_abort = 1'b0;
`endif
      timed_out = (k >= 400) ? 1 : 0;
      @(negedge clk_48mhz);
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      reset_n = 1'b0;
      tx_pkt_start = 1'b0;
      tx_data_valid = 1'b0;
      tx_data = 8'h00;
`ifdef USB_TX_PKT_ABORT_EN
      tx_abort = 1'b0;
`endif
      repeat (3) @(negedge clk_48mhz);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_48mhz);
         obs = {usb_tx_en, usb_p_tx, usb_n_tx, tx_busy, tx_data_get};
         checks++;
         if (obs !== 5'b01000) begin
            errors++;
            $display("FAIL reset_idle clk %0d: en,p,n,busy,get=%b expected 01000", i, obs);
         end
      end
   endtask

   task automatic test_single_byte();
      logic [1:0] exp_line [0:18];
      int to;
      exp_line = '{LK,LJ,LK,LJ,LK,LJ,LK,LK, LK,LJ,LJ,LK,LJ,LJ,LK,LK, LS,LS,LJ};
      tb_bytes[0] = 8'hA5;
      tb_nbytes = 1;
      send_packet(-1, -1, to);
      checks++;
      if (to !== 0) begin errors++; $display("FAIL single_timeout: got %0d expected 0", to); end
      checks++;
      if (mon_en_clks !== 76) begin errors++; $display("FAIL single_len: en clocks %0d expected 76", mon_en_clks); end
      checks++;
      if (mon_n !== 19) begin errors++; $display("FAIL single_bits: bit periods %0d expected 19", mon_n); end
      for (int i = 0; i < 19; i++) begin
         checks++;
         if (mon_line[i] !== exp_line[i]) begin
            errors++;
            $display("FAIL single_line bit %0d: {n,p}=%b expected %b", i, mon_line[i], exp_line[i]);
         end
      end
      checks++;
      if (mon_gets !== 1) begin errors++; $display("FAIL single_gets: %0d expected 1", mon_gets); end
      checks++;
      if (mon_get_pos[0] !== 32) begin errors++; $display("FAIL single_get_pos: clock %0d expected 32", mon_get_pos[0]); end
      checks++;
      if (mon_glitch !== 0) begin errors++; $display("FAIL single_hold: %0d mid-bit changes expected 0", mon_glitch); end
      checks++;
      if (mon_busy_err !== 0) begin errors++; $display("FAIL single_busy: %0d clocks busy!=en expected 0", mon_busy_err); end
   endtask

   task automatic test_stuffing();
      logic [1:0] exp_line [0:28];
      int to;
      exp_line = '{LK,LJ,LK,LJ,LK,LJ,LK,LK,
                   LK,LK,LK,LK,LK, LJ, LJ,LJ,LJ,
                   LJ,LJ,LJ, LK, LK,LK,LK,LK,LK,
                   LS,LS,LJ};
      tb_bytes[0] = 8'hFF;
      tb_bytes[1] = 8'hFF;
      tb_nbytes = 2;
      send_packet(-1, -1, to);
      checks++;
      if (to !== 0) begin errors++; $display("FAIL stuff_timeout: got %0d expected 0", to); end
      checks++;
      if (mon_en_clks !== 116) begin errors++; $display("FAIL stuff_len: en clocks %0d expected 116", mon_en_clks); end
      checks++;
      if (mon_n !== 29) begin errors++; $display("FAIL stuff_bits: bit periods %0d expected 29", mon_n); end
      for (int i = 0; i < 29; i++) begin
         checks++;
         if (mon_line[i] !== exp_line[i]) begin
            errors++;
            $display("FAIL stuff_line bit %0d: {n,p}=%b expected %b", i, mon_line[i], exp_line[i]);
         end
      end
      checks++;
      if (mon_gets !== 2) begin errors++; $display("FAIL stuff_gets: %0d expected 2", mon_gets); end
      checks++;
      if (mon_get_pos[1] !== 68) begin errors++; $display("FAIL stuff_get_pos: clock %0d expected 68", mon_get_pos[1]); end
      checks++;
      if (mon_glitch !== 0) begin errors++; $display("FAIL stuff_hold: %0d mid-bit changes expected 0", mon_glitch); end
   endtask

   task automatic test_zero_len_busy();
      logic [1:0] exp_line [0:10];
      int to;
      int en_seen;
      exp_line = '{LK,LJ,LK,LJ,LK,LJ,LK,LK, LS,LS,LJ};
      tb_nbytes = 0;
      send_packet(10, -1, to);
      checks++;
      if (to !== 0) begin errors++; $display("FAIL zlp_timeout: got %0d expected 0", to); end
      checks++;
      if (mon_en_clks !== 44) begin errors++; $display("FAIL zlp_len: en clocks %0d expected 44", mon_en_clks); end
      checks++;
      if (mon_n !== 11) begin errors++; $display("FAIL zlp_bits: bit periods %0d expected 11", mon_n); end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (mon_line[i] !== exp_line[i]) begin
            errors++;
            $display("FAIL zlp_line bit %0d: {n,p}=%b expected %b", i, mon_line[i], exp_line[i]);
         end
      end
      checks++;
      if (mon_gets !== 0) begin errors++; $display("FAIL zlp_gets: %0d expected 0", mon_gets); end
      en_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_48mhz);
         if (usb_tx_en !== 1'b0) en_seen++;
      end
      checks++;
      if (en_seen !== 0) begin errors++; $display("FAIL zlp_second_start: en high %0d clocks expected 0", en_seen); end
   endtask

   task automatic test_reset_mid();
      logic [4:0] obs;
      int bad;
      tx_data = 8'hA5;
      tx_data_valid = 1'b1;
      @(negedge clk_48mhz);
      tx_pkt_start = 1'b1;
      @(negedge clk_48mhz);
      tx_pkt_start = 1'b0;
      repeat (45) @(negedge clk_48mhz);
      checks++;
      if (w_code !== LK || usb_tx_en !== 1'b1) begin
         errors++;
         $display("FAIL midrst_bit3: en=%b {n,p}=%b expected en=1 %b", usb_tx_en, w_code, LK);
      end
      reset_n = 1'b0;
      @(negedge clk_48mhz);
      obs = {usb_tx_en, usb_p_tx, usb_n_tx, tx_busy, tx_data_get};
      checks++;
      if (obs !== 5'b01000) begin
         errors++;
         $display("FAIL midrst_abandon: en,p,n,busy,get=%b expected 01000", obs);
      end
      tx_pkt_start = 1'b1;
      @(negedge clk_48mhz);
      tx_pkt_start = 1'b0;
      tx_data_valid = 1'b0;
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_48mhz);
         if ({usb_tx_en, usb_p_tx, usb_n_tx} !== 3'b010) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL midrst_quiet: %0d non-idle clocks expected 0", bad); end
   endtask

`ifdef USB_TX_PKT_ABORT_EN
   task automatic test_abort();
      logic [1:0] exp_line [0:21];
      int to;
      exp_line = '{LK,LJ,LK,LJ,LK,LJ,LK,LK, LK,LJ,LJ,
                   LJ,LJ,LJ,LJ,LJ,LJ,LJ,LJ, LS,LS,LJ};
      tb_bytes[0] = 8'hA5;
      tb_bytes[1] = 8'h3C;
      tb_bytes[2] = 8'h0F;
      tb_nbytes = 3;
      send_packet(-1, 41, to);
      checks++;
      if (to !== 0) begin errors++; $display("FAIL abort_timeout: got %0d expected 0", to); end
      checks++;
      if (mon_n !== 22) begin errors++; $display("FAIL abort_bits: bit periods %0d expected 22", mon_n); end
      for (int i = 0; i < 22; i++) begin
         checks++;
         if (mon_line[i] !== exp_line[i]) begin
            errors++;
            $display("FAIL abort_line bit %0d: {n,p}=%b expected %b", i, mon_line[i], exp_line[i]);
         end
      end
      checks++;
      if (mon_gets !== 1) begin errors++; $display("FAIL abort_gets: %0d expected 1", mon_gets); end
      checks++;
      if (mon_en_clks !== 88) begin errors++; $display("FAIL abort_len: en clocks %0d expected 88", mon_en_clks); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_stuffing();
      test_zero_len_busy();
      test_reset_mid();
`ifdef USB_TX_PKT_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
